// File: rtl/sprite_compositor.sv
// sprite_compositor: two-stage pixel compositor for the VGA path.
// Stage 1 registers per-sprite rectangle hits, display and sprite colours.
// Stage 2 resolves priority, applies the game-mode overlay and registers VGA_R/G/B.
// A PLAY/WIN/LOSE mode machine selects gameplay or banner rendering.
// A frame counter blinks the banner background.
// Optional feature: define SPRITE_COMPOSITOR_GROUND_EN to draw a white ground strip
// below all sprites in PLAY.
`timescale 1ns/1ps

module sprite_compositor #(
  parameter int NUM_SPRITES = 5,
  parameter int COORD_W     = 32,
  parameter int BLINK_LOG2  = 5
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              display,
  input  logic                              frame_start,
  input  logic [COORD_W-1:0]                X,
  input  logic [COORD_W-1:0]                Y,
  input  logic [NUM_SPRITES*4*COORD_W-1:0]  box,
  input  logic [NUM_SPRITES*24-1:0]         color,
  input  logic [NUM_SPRITES-1:0]            sprite_en,
  input  logic                              win,
  input  logic                              lose,
  input  logic                              restart,
  output logic [7:0]                        VGA_R,
  output logic [7:0]                        VGA_G,
  output logic [7:0]                        VGA_B,
  output logic [1:0]                        mode
);

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    WIN  = 2'd1,
    LOSE = 2'd2
  } mode_e;

  localparam logic [23:0] RGB_BLACK = 24'h000000;
  localparam logic [23:0] RGB_WHITE = 24'hFFFFFF;
  localparam logic [23:0] RGB_GREEN = 24'h00FF00;
  localparam logic [23:0] RGB_RED   = 24'hFF0000;
  localparam logic [23:0] RGB_BLUE  = 24'h0000FF;

  mode_e                     state;
  mode_e                     state_next;
  logic [BLINK_LOG2:0]       blink_cnt;
  logic                      blink_phase;

  logic [NUM_SPRITES-1:0]    hit_d;
  logic [NUM_SPRITES-1:0]    hit_q;
  logic                      display_q;
  logic [NUM_SPRITES*24-1:0] color_q;

  logic [23:0]               sprite_rgb;
  logic                      sprite_hit;
  logic [23:0]               pixel_d;
  logic [23:0]               pixel_q;

`ifdef SPRITE_COMPOSITOR_GROUND_EN
  logic                      ground_d;
  logic                      ground_q;
`endif

  // Stage 1 combinational hit test: exclusive low edge, inclusive high edge, unsigned.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    hit_d = '0;
    for (int k = 0; k < NUM_SPRITES; k++) begin
      hit_d[k] = sprite_en[k]
               & (X >  box[k*4*COORD_W             +: COORD_W])
               & (Y >  box[k*4*COORD_W + COORD_W   +: COORD_W])
               & (X <= box[k*4*COORD_W + 2*COORD_W +: COORD_W])
               & (Y <= box[k*4*COORD_W + 3*COORD_W +: COORD_W]);
    end
  end

`ifdef SPRITE_COMPOSITOR_GROUND_EN
  // Ground strip hit test, fixed screen rectangle.
  always_comb begin
    ground_d = (X > COORD_W'(32))  && (X <= COORD_W'(1248)) &&
               (Y > COORD_W'(800)) && (Y <= COORD_W'(816));
  end
`endif

  // Stage 1 pipeline registers; colours travel with their hits to keep 2-cycle latency.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      hit_q     <= '0;
      display_q <= 1'b0;
      color_q   <= '0;
`ifdef SPRITE_COMPOSITOR_GROUND_EN
      ground_q  <= 1'b0;
`endif
    end else begin
      hit_q     <= hit_d;
      display_q <= display;
      color_q   <= color;
`ifdef SPRITE_COMPOSITOR_GROUND_EN
      ground_q  <= ground_d;
`endif
    end
  end

  // Mode state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= PLAY;
    end else begin
      state <= state_next;
    end
  end

  // Mode next-state: restart beats win/lose, lose beats win, LOSE ignores win.
  always_comb begin
    state_next = state;
    case (state)
      PLAY: begin
        if (lose)     state_next = LOSE;
        else if (win) state_next = WIN;
      end
      WIN: begin
        if (restart)   state_next = PLAY;
        else if (lose) state_next = LOSE;
      end
      LOSE: begin
        if (restart) state_next = PLAY;
      end
      default: state_next = PLAY;
    endcase
  end

  // Mode output decode.
  always_comb begin
    mode = state;
  end

  // Blink counter: cleared on any transition, else counts frames in the banner modes.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt <= '0;
    end else if (state_next != state) begin
      blink_cnt <= '0;
    end else if (frame_start && (state != PLAY)) begin
      blink_cnt <= blink_cnt + {{BLINK_LOG2{1'b0}}, 1'b1};
    end
  end

  assign blink_phase = blink_cnt[BLINK_LOG2];

  // Stage 2 priority select: the lowest-index hitting sprite wins.
  always_comb begin
    sprite_rgb = RGB_BLACK;
    sprite_hit = 1'b0;
    for (int k = NUM_SPRITES - 1; k >= 0; k--) begin
      if (hit_q[k]) begin
        sprite_rgb = color_q[k*24 +: 24];
        sprite_hit = 1'b1;
      end
    end
  end

  // Stage 2 mode overlay using the registered mode.
  always_comb begin
    pixel_d = RGB_BLACK;
    if (display_q) begin
      case (state)
        PLAY: begin
          if (sprite_hit) pixel_d = sprite_rgb;
`ifdef SPRITE_COMPOSITOR_GROUND_EN
          else if (ground_q) pixel_d = RGB_WHITE;
`endif
        end
        WIN: begin
          if (hit_q[0])          pixel_d = RGB_WHITE;
          else if (!blink_phase) pixel_d = RGB_GREEN;
        end
        LOSE: begin
          if (hit_q[0])          pixel_d = RGB_BLUE;
          else if (!blink_phase) pixel_d = RGB_RED;
        end
        default: pixel_d = RGB_BLACK;
      endcase
    end
  end

  // Stage 2 output register driving the DAC pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_q <= RGB_BLACK;
    end else begin
      pixel_q <= pixel_d;
    end
  end

  assign VGA_R = pixel_q[23:16];
  assign VGA_G = pixel_q[15:8];
  assign VGA_B = pixel_q[7:0];

endmodule
